// File: rtl/tff_count_sequencer.sv
// tff_count_sequencer
//
// Owns a bank of WIDTH T flip-flops and drives their toggle enables so the
// bank behaves as a synchronous up/down binary counter for a commanded
// number of steps. Commands are taken over a valid/ready handshake and
// completion is reported with a single-cycle done pulse.
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      synchronous, active-low reset (0 = reset)
//   cmd_valid  command request
//   cmd_ready  high in IDLE (and out of reset): a command can be taken
//   cmd_dir    1 = count up, 0 = count down; captured at accept
//   cmd_len    number of count steps; captured at accept (0 = no steps)
//   pause      freezes an in-progress sequence for the cycle
//   t          toggle enables applied to the bank this cycle
//   q          current T flip-flop bank state
//   busy       high while a sequence is running or finishing
//   done       one-cycle completion pulse
module tff_count_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [WIDTH-1:0] cmd_len,
    input  logic             pause,
    output logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] LEN_ONE = WIDTH'(1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] remaining_reg;
    logic [WIDTH-1:0] remaining_next;
    logic             dir_reg;
    logic             dir_next;

    // Carry/borrow chains: bit i toggles when every lower bit is 1 (up)
    // or every lower bit is 0 (down). Bit 0 always toggles.
    logic [WIDTH-1:0] up_chain;
    logic [WIDTH-1:0] down_chain;
    logic [WIDTH-1:0] step_t;

    assign up_chain[0]   = 1'b1;
    assign down_chain[0] = 1'b1;

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_chain
            assign up_chain[gi]   = up_chain[gi-1] & q_reg[gi-1];
            assign down_chain[gi] = down_chain[gi-1] & ~q_reg[gi-1];
        end
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_step
            assign step_t[gi] = dir_reg ? up_chain[gi] : down_chain[gi];
        end
    endgenerate

    assign q = q_reg;

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        dir_next       = dir_reg;

        // Outputs are masked while reset is asserted so the bank never
        // toggles and no handshake is offered during reset.
        cmd_ready = reset && (state_reg == ST_IDLE);
        busy      = reset && (state_reg != ST_IDLE);
        done      = reset && (state_reg == ST_DONE);
        t         = (reset && (state_reg == ST_RUN) && !pause) ? step_t : '0;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    dir_next = cmd_dir;
                    if (cmd_len != '0) begin
                        state_next     = ST_RUN;
                        remaining_next = cmd_len;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (!pause) begin
                    remaining_next = remaining_reg - LEN_ONE;
                    if (remaining_reg == LEN_ONE) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            q_reg         <= '0;
            remaining_reg <= '0;
            dir_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            q_reg         <= q_reg ^ t;
            remaining_reg <= remaining_next;
            dir_reg       <= dir_next;
        end
    end

endmodule
